// File: rtl/inst_fetcher_pkg.sv
// rtl/inst_fetcher_pkg.sv - shared opcode constants and fetch state encoding
package inst_fetcher_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } ifetch_state_e;

endpackage

// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - ICache, Issue queue and ROB signals of the instruction fetcher
interface inst_fetcher_if;
    logic        _clear;
    logic [31:0] _clear_pc;
    logic        _jalr_done;
    logic [31:0] _jalr_pc;
    logic        _icache_valid;
    logic [31:0] _icache_addr;
    logic        _icache_ready;
    logic [31:0] _icache_inst;
    logic        _issue_need_inst;
    logic        _inst_ready_out;
    logic [31:0] _inst_out;
    logic [31:0] _inst_addr_out;
    logic [31:0] _jalr_rd_out;

    modport master (
        input  _clear, _clear_pc, _jalr_done, _jalr_pc,
        input  _icache_ready, _icache_inst, _issue_need_inst,
        output _icache_valid, _icache_addr,
        output _inst_ready_out, _inst_out, _inst_addr_out, _jalr_rd_out
    );

    modport slave (
        output _clear, _clear_pc, _jalr_done, _jalr_pc,
        output _icache_ready, _icache_inst, _issue_need_inst,
        input  _icache_valid, _icache_addr,
        input  _inst_ready_out, _inst_out, _inst_addr_out, _jalr_rd_out
    );
endinterface

// File: rtl/inst_fetcher_next_pc.sv
// rtl/inst_fetcher_next_pc.sv - opcode decode and next-PC adder (IFETCH_JAL_REDIRECT_EN enables JAL redirect)
module ifetch_next_pc
    import inst_fetcher_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] next_pc,
    output logic        stall
);

    logic [31:0] imm_b;
    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

`ifdef IFETCH_JAL_REDIRECT_EN
    logic [31:0] imm_jal;
    assign imm_jal = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
`else
    logic unused_jal_bits;
    assign unused_jal_bits = ^inst[24:12];
`endif

    always_comb begin
        next_pc = pc + 32'd4;
        stall   = 1'b0;
        case (inst[6:0])
            OP_BRANCH: next_pc = pc + imm_b;
`ifdef IFETCH_JAL_REDIRECT_EN
            OP_JAL:    next_pc = pc + imm_jal;
            OP_JALR: begin
                next_pc = pc;
                stall   = 1'b1;
            end
`else
            // Without fetch-time redirect, JAL waits for the ROB exactly like JALR.
            OP_JAL, OP_JALR: begin
                next_pc = pc;
                stall   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - PC holder issuing one outstanding ICache fetch and pushing words to Issue
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
)
(
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    inst_fetcher_if.master bus
);

    ifetch_state_e state;
    logic [31:0]   pc;
    logic [31:0]   next_pc;
    logic          stall;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          push_valid;
    logic [31:0]   push_inst;
    logic [31:0]   push_addr;
    logic [31:0]   push_rd;
    logic          skid_full;
    logic [31:0]   skid_inst;
    logic [31:0]   skid_addr;
    logic          discard;

    ifetch_next_pc u_next_pc (
        .pc      (pc),
        .inst    (bus._icache_inst),
        .next_pc (next_pc),
        .stall   (stall)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            req_valid  <= 1'b0;
            req_addr   <= 32'h0;
            push_valid <= 1'b0;
            push_inst  <= 32'h0;
            push_addr  <= 32'h0;
            push_rd    <= 32'h0;
            skid_full  <= 1'b0;
            skid_inst  <= 32'h0;
            skid_addr  <= 32'h0;
            discard    <= 1'b0;
        end else if (rdy_in) begin
            push_valid <= 1'b0;
            if (bus._clear) begin
                pc        <= bus._clear_pc;
                state     <= ST_FETCH;
                skid_full <= 1'b0;
                req_valid <= 1'b0;
                // A response still in flight must be swallowed unless it lands right now.
                discard   <= (discard || state == ST_WAIT) && !bus._icache_ready;
            end else begin
                if (skid_full && bus._issue_need_inst) begin
                    push_valid <= 1'b1;
                    push_inst  <= skid_inst;
                    push_addr  <= skid_addr;
                    push_rd    <= skid_addr + 32'd4;
                    skid_full  <= 1'b0;
                end
                if (discard && bus._icache_ready)
                    discard <= 1'b0;
                case (state)
                    ST_FETCH: begin
                        if (!skid_full && !discard && bus._issue_need_inst) begin
                            req_valid <= 1'b1;
                            req_addr  <= pc;
                            state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus._icache_ready) begin
                            req_valid <= 1'b0;
                            pc        <= next_pc;
                            state     <= stall ? ST_STALL : ST_FETCH;
                            if (bus._issue_need_inst) begin
                                push_valid <= 1'b1;
                                push_inst  <= bus._icache_inst;
                                push_addr  <= pc;
                                push_rd    <= pc + 32'd4;
                            end else begin
                                skid_full <= 1'b1;
                                skid_inst <= bus._icache_inst;
                                skid_addr <= pc;
                            end
                        end
                    end
                    ST_STALL: begin
                        if (bus._jalr_done) begin
                            pc    <= bus._jalr_pc;
                            state <= ST_FETCH;
                        end
                    end
                    default: state <= ST_FETCH;
                endcase
            end
        end
    end

    assign bus._icache_valid   = req_valid;
    assign bus._icache_addr    = req_addr;
    assign bus._inst_ready_out = push_valid & rdy_in;
    assign bus._inst_out       = push_inst;
    assign bus._inst_addr_out  = push_addr;
    assign bus._jalr_rd_out    = push_rd;

endmodule
